slt_rs_ctrl: RTL and testbench

Reservation-station controller that sequences the shared LUI/SLT/SLTU functional unit in the dynamic (Tomasulo-style) pipeline. It accepts dispatched instructions with possibly-unresolved operands and captures operand values from the common data bus (CDB). It issues the oldest ready entry to the combinational unit through a one-stage execute register, then holds each result in a writeback register until the CDB grants it.

---
 rtl/slt_rs_if.sv | 52 +++++
 rtl/slt_rs_ctrl.sv | 174 +++++++++++++++++
 tb/tb_slt_rs_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/slt_rs_if.sv
// Dispatch, CDB snoop, functional-unit and writeback signals for the LUI/SLT/SLTU
// reservation station. The controller takes the slave side.
interface slt_rs_if #(
    parameter int TAG_W = 4
);
    logic             disp_valid;
    logic             disp_ready;
    logic [1:0]       disp_aluc;
    logic [TAG_W-1:0] disp_tag;
    logic             disp_rdy1;
    logic             disp_rdy2;
    logic [TAG_W-1:0] disp_q1;
    logic [TAG_W-1:0] disp_q2;
    logic [31:0]      disp_v1;
    logic [31:0]      disp_v2;

    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;

    logic [31:0]      fu_alu1;
    logic [31:0]      fu_alu2;
    logic [1:0]       fu_aluc;
    logic [31:0]      fu_res;

    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_data;
    logic             wb_ready;

    modport master (
        output disp_valid, disp_aluc, disp_tag, disp_rdy1, disp_rdy2,
               disp_q1, disp_q2, disp_v1, disp_v2,
        input  disp_ready,
        output cdb_valid, cdb_tag, cdb_data,
        input  fu_alu1, fu_alu2, fu_aluc,
        output fu_res,
        input  wb_valid, wb_tag, wb_data,
        output wb_ready
    );

    modport slave (
        input  disp_valid, disp_aluc, disp_tag, disp_rdy1, disp_rdy2,
               disp_q1, disp_q2, disp_v1, disp_v2,
        output disp_ready,
        input  cdb_valid, cdb_tag, cdb_data,
        output fu_alu1, fu_alu2, fu_aluc,
        input  fu_res,
        output wb_valid, wb_tag, wb_data,
        input  wb_ready
    );
endinterface

// File: rtl/slt_rs_ctrl.sv
// Reservation station for the shared LUI/SLT/SLTU unit: oldest-ready issue into a
// one-stage EX register, result held in a WB register until the CDB grants it.
module slt_rs_ctrl #(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = 4,
    localparam int OCC_W  = $clog2(ENTRIES + 1),
    localparam int IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    slt_rs_if.slave          rs,
    output logic [OCC_W-1:0] occupancy
);
    logic             e_valid [ENTRIES];
    logic [1:0]       e_aluc  [ENTRIES];
    logic [TAG_W-1:0] e_tag   [ENTRIES];
    logic             e_rdy1  [ENTRIES];
    logic             e_rdy2  [ENTRIES];
    logic [TAG_W-1:0] e_q1    [ENTRIES];
    logic [TAG_W-1:0] e_q2    [ENTRIES];
    logic [31:0]      e_v1    [ENTRIES];
    logic [31:0]      e_v2    [ENTRIES];
    logic [OCC_W-1:0] e_rank  [ENTRIES];

    logic             ex_valid;
    logic [TAG_W-1:0] ex_tag;
    logic [1:0]       ex_aluc;
    logic [31:0]      ex_v1;
    logic [31:0]      ex_v2;

    logic             wb_valid_q;
    logic [TAG_W-1:0] wb_tag_q;
    logic [31:0]      wb_data_q;

    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             iss_found;
    logic [IDX_W-1:0] iss_idx;
    logic [OCC_W-1:0] iss_rank;

    logic wb_fire;
    logic ex_adv;
    logic iss_fire;
    logic disp_fire;
    logic byp1;
    logic byp2;

    always_comb begin
        occupancy  = '0;
        free_found = 1'b0;
        free_idx   = '0;
        iss_found  = 1'b0;
        iss_idx    = '0;
        iss_rank   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            occupancy = occupancy + OCC_W'(e_valid[i]);
            if (!e_valid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (e_valid[i] && e_rdy1[i] && e_rdy2[i] && (!iss_found || e_rank[i] < iss_rank)) begin
                iss_found = 1'b1;
                iss_idx   = IDX_W'(i);
                iss_rank  = e_rank[i];
            end
        end
    end

    // disp_ready looks only at registered occupancy; a same-cycle issue never makes room
    assign rs.disp_ready = rst_n && (occupancy < OCC_W'(ENTRIES));

    assign wb_fire   = wb_valid_q && rs.wb_ready;
    assign ex_adv    = ex_valid && (!wb_valid_q || wb_fire);
    assign iss_fire  = !flush && iss_found && (!ex_valid || ex_adv);
    assign disp_fire = !flush && rs.disp_valid && rs.disp_ready;
    assign byp1      = rs.cdb_valid && (rs.disp_q1 == rs.cdb_tag);
    assign byp2      = rs.cdb_valid && (rs.disp_q2 == rs.cdb_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                e_valid[i] <= 1'b0;
                e_aluc[i]  <= '0;
                e_tag[i]   <= '0;
                e_rdy1[i]  <= 1'b0;
                e_rdy2[i]  <= 1'b0;
                e_q1[i]    <= '0;
                e_q2[i]    <= '0;
                e_v1[i]    <= '0;
                e_v2[i]    <= '0;
                e_rank[i]  <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                e_valid[i] <= 1'b0;
                e_rank[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (e_valid[i] && !e_rdy1[i] && rs.cdb_valid && e_q1[i] == rs.cdb_tag) begin
                    e_rdy1[i] <= 1'b1;
                    e_v1[i]   <= rs.cdb_data;
                end
                if (e_valid[i] && !e_rdy2[i] && rs.cdb_valid && e_q2[i] == rs.cdb_tag) begin
                    e_rdy2[i] <= 1'b1;
                    e_v2[i]   <= rs.cdb_data;
                end
                if (iss_fire && IDX_W'(i) == iss_idx) begin
                    e_valid[i] <= 1'b0;
                end else if (iss_fire && e_valid[i] && e_rank[i] > iss_rank) begin
                    e_rank[i] <= e_rank[i] - OCC_W'(1);
                end
                // free_idx is never the issuing entry, so the two updates cannot collide
                if (disp_fire && IDX_W'(i) == free_idx) begin
                    e_valid[i] <= 1'b1;
                    e_aluc[i]  <= rs.disp_aluc;
                    e_tag[i]   <= rs.disp_tag;
                    e_q1[i]    <= rs.disp_q1;
                    e_q2[i]    <= rs.disp_q2;
                    e_rdy1[i]  <= !rs.disp_aluc[1] || rs.disp_rdy1 || byp1;
                    e_rdy2[i]  <= rs.disp_rdy2 || byp2;
                    e_v1[i]    <= (rs.disp_rdy1 || !byp1) ? rs.disp_v1 : rs.cdb_data;
                    e_v2[i]    <= (rs.disp_rdy2 || !byp2) ? rs.disp_v2 : rs.cdb_data;
                    e_rank[i]  <= iss_fire ? occupancy - OCC_W'(1) : occupancy;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_tag   <= '0;
            ex_aluc  <= '0;
            ex_v1    <= '0;
            ex_v2    <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (iss_fire) begin
            ex_valid <= 1'b1;
            ex_tag   <= e_tag[iss_idx];
            ex_aluc  <= e_aluc[iss_idx];
            ex_v1    <= e_v1[iss_idx];
            ex_v2    <= e_v2[iss_idx];
        end else if (ex_adv) begin
            ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_tag_q   <= '0;
            wb_data_q  <= '0;
        end else if (flush) begin
            wb_valid_q <= 1'b0;
        end else if (ex_adv) begin
            wb_valid_q <= 1'b1;
            wb_tag_q   <= ex_tag;
            wb_data_q  <= rs.fu_res;
        end else if (wb_fire) begin
            wb_valid_q <= 1'b0;
        end
    end

    assign rs.fu_alu1 = ex_valid ? ex_v1   : '0;
    assign rs.fu_alu2 = ex_valid ? ex_v2   : '0;
    assign rs.fu_aluc = ex_valid ? ex_aluc : '0;

    assign rs.wb_valid = wb_valid_q;
    assign rs.wb_tag   = wb_valid_q ? wb_tag_q  : '0;
    assign rs.wb_data  = wb_valid_q ? wb_data_q : '0;
endmodule

// File: tb/tb_slt_rs_ctrl.sv
// Directed bench for slt_rs_ctrl: table of single-op vectors plus hand-written
// multi-cycle sequences (ordering, CDB wakeup, bypass, backpressure, flush, reset).
module tb_slt_rs_ctrl;
    localparam int ENTRIES = 4;
    localparam int TAG_W   = 4;
    localparam int OCC_W   = $clog2(ENTRIES + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic [OCC_W-1:0] occupancy;

    slt_rs_if #(.TAG_W(TAG_W)) rs ();

    slt_rs_ctrl #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .rs(rs),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // behavioural functional unit
    always_comb begin
        rs.fu_res = '0;
        case (rs.fu_aluc)
            2'b10:   rs.fu_res = {31'd0, (rs.fu_alu1 < rs.fu_alu2)};
            2'b11:   rs.fu_res = {31'd0, ($signed(rs.fu_alu1) < $signed(rs.fu_alu2))};
            default: rs.fu_res = {rs.fu_alu2[15:0], 16'h0000};
        endcase
    end

    int n_pass = 0;
    int n_total = 0;
    logic [TAG_W-1:0] got_tag[$];
    logic [31:0]      got_data[$];

    always @(negedge clk) begin
        if (rst_n && rs.wb_valid && rs.wb_ready) begin
            got_tag.push_back(rs.wb_tag);
            got_data.push_back(rs.wb_data);
        end
    end

    typedef struct {
        logic [1:0]       aluc;
        logic [31:0]      v1;
        logic [31:0]      v2;
        logic [TAG_W-1:0] tag;
        logic [31:0]      exp;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs.disp_valid = 1'b0;
        rs.disp_aluc  = '0;
        rs.disp_tag   = '0;
        rs.disp_rdy1  = 1'b0;
        rs.disp_rdy2  = 1'b0;
        rs.disp_q1    = '0;
        rs.disp_q2    = '0;
        rs.disp_v1    = '0;
        rs.disp_v2    = '0;
        rs.cdb_valid  = 1'b0;
        rs.cdb_tag    = '0;
        rs.cdb_data   = '0;
    endtask

    task automatic set_disp(input logic [1:0] aluc, input logic [TAG_W-1:0] tag,
                            input logic r1, input logic [TAG_W-1:0] q1, input logic [31:0] v1,
                            input logic r2, input logic [TAG_W-1:0] q2, input logic [31:0] v2);
        rs.disp_valid = 1'b1;
        rs.disp_aluc  = aluc;
        rs.disp_tag   = tag;
        rs.disp_rdy1  = r1;
        rs.disp_q1    = q1;
        rs.disp_v1    = v1;
        rs.disp_rdy2  = r2;
        rs.disp_q2    = q2;
        rs.disp_v2    = v2;
    endtask

    // present a dispatch and step until it is accepted (bounded)
    task automatic send(input logic [1:0] aluc, input logic [TAG_W-1:0] tag,
                        input logic r1, input logic [TAG_W-1:0] q1, input logic [31:0] v1,
                        input logic r2, input logic [TAG_W-1:0] q2, input logic [31:0] v2);
        logic acc;
        acc = 1'b0;
        set_disp(aluc, tag, r1, q1, v1, r2, q2, v2);
        for (int t = 0; t < 40 && !acc; t++) begin
            acc = rs.disp_ready;
            step();
        end
        rs.disp_valid = 1'b0;
        if (!acc) check("disp_accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic check_all_zero(input string tagname);
        check({tagname, "_disp_ready"}, 32'(rs.disp_ready), 32'd0);
        check({tagname, "_occupancy"},  32'(occupancy), 32'd0);
        check({tagname, "_wb_valid"},   32'(rs.wb_valid), 32'd0);
        check({tagname, "_wb_tag"},     32'(rs.wb_tag), 32'd0);
        check({tagname, "_wb_data"},    rs.wb_data, 32'd0);
        check({tagname, "_fu_alu1"},    rs.fu_alu1, 32'd0);
        check({tagname, "_fu_alu2"},    rs.fu_alu2, 32'd0);
        check({tagname, "_fu_aluc"},    32'(rs.fu_aluc), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 4'd5,  32'd1};
        vecs[1] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 4'd6,  32'd0};
        vecs[2] = '{2'b00, 32'hDEAD_BEEF, 32'h0000_1234, 4'd7,  32'h1234_0000};
        vecs[3] = '{2'b01, 32'h0000_0000, 32'hABCD_FFFF, 4'd8,  32'hFFFF_0000};
        vecs[4] = '{2'b11, 32'h8000_0000, 32'h7FFF_FFFF, 4'd9,  32'd1};
        vecs[5] = '{2'b10, 32'h8000_0000, 32'h7FFF_FFFF, 4'd10, 32'd0};
        vecs[6] = '{2'b11, 32'h0000_0005, 32'h0000_0005, 4'd11, 32'd0};
        vecs[7] = '{2'b10, 32'h0000_0003, 32'h0000_0004, 4'd12, 32'd1};

        idle();
        rs.wb_ready = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        #1;
        check("reset_release_disp_ready", 32'(rs.disp_ready), 32'd1);
        step();

        // single ops at minimum latency
        for (int k = 0; k < 8; k++) begin
            send(vecs[k].aluc, vecs[k].tag, 1'b1, '0, vecs[k].v1, 1'b1, '0, vecs[k].v2);
            check($sformatf("vec%0d_occ_c1", k), 32'(occupancy), 32'd1);
            step();
            check($sformatf("vec%0d_fu_aluc_c2", k), 32'(rs.fu_aluc), 32'(vecs[k].aluc));
            step();
            check($sformatf("vec%0d_wb_valid", k), 32'(rs.wb_valid), 32'd1);
            check($sformatf("vec%0d_wb_tag", k), 32'(rs.wb_tag), 32'(vecs[k].tag));
            check($sformatf("vec%0d_wb_data", k), rs.wb_data, vecs[k].exp);
            repeat (2) step();
        end

        // back-to-back slt / sltu / lui
        send(2'b11, 4'd5, 1'b1, '0, 32'hFFFF_FFFF, 1'b1, '0, 32'd1);
        send(2'b10, 4'd6, 1'b1, '0, 32'hFFFF_FFFF, 1'b1, '0, 32'd1);
        send(2'b00, 4'd7, 1'b1, '0, 32'd0, 1'b1, '0, 32'h0000_1234);
        check("b2b_c3_valid", 32'(rs.wb_valid), 32'd1);
        check("b2b_c3_tag", 32'(rs.wb_tag), 32'd5);
        check("b2b_c3_data", rs.wb_data, 32'd1);
        step();
        check("b2b_c4_tag", 32'(rs.wb_tag), 32'd6);
        check("b2b_c4_data", rs.wb_data, 32'd0);
        step();
        check("b2b_c5_tag", 32'(rs.wb_tag), 32'd7);
        check("b2b_c5_data", rs.wb_data, 32'h1234_0000);
        repeat (3) step();

        // waiting operand woken by the CDB; younger ready op overtakes
        send(2'b11, 4'd1, 1'b0, 4'd9, 32'd0, 1'b1, '0, 32'd0);
        send(2'b10, 4'd2, 1'b1, '0, 32'd2, 1'b1, '0, 32'd1);
        check("wake_c2_occ", 32'(occupancy), 32'd2);
        step();
        check("wake_c3_wb_valid", 32'(rs.wb_valid), 32'd0);
        step();
        check("wake_c4_tag", 32'(rs.wb_tag), 32'd2);
        check("wake_c4_data", rs.wb_data, 32'd0);
        rs.cdb_valid = 1'b1;
        rs.cdb_tag   = 4'd9;
        rs.cdb_data  = 32'h8000_0000;
        step();
        idle();
        check("wake_c5_occ", 32'(occupancy), 32'd1);
        step();
        check("wake_c6_occ", 32'(occupancy), 32'd0);
        check("wake_c6_wb_valid", 32'(rs.wb_valid), 32'd0);
        step();
        check("wake_c7_wb_valid", 32'(rs.wb_valid), 32'd1);
        check("wake_c7_tag", 32'(rs.wb_tag), 32'd1);
        check("wake_c7_data", rs.wb_data, 32'd1);
        repeat (3) step();

        // dispatch bypass from same-cycle CDB
        rs.cdb_valid = 1'b1;
        rs.cdb_tag   = 4'd3;
        rs.cdb_data  = 32'd5;
        send(2'b10, 4'd4, 1'b1, '0, 32'd2, 1'b0, 4'd3, 32'd0);
        idle();
        repeat (2) step();
        check("bypass_wb_valid", 32'(rs.wb_valid), 32'd1);
        check("bypass_wb_tag", 32'(rs.wb_tag), 32'd4);
        check("bypass_wb_data", rs.wb_data, 32'd1);
        repeat (3) step();

        // backpressure: 6 accepted, 7th stalls, drain in order
        got_tag.delete();
        got_data.delete();
        rs.wb_ready = 1'b0;
        for (int k = 0; k < 6; k++)
            send(2'b00, TAG_W'(k + 1), 1'b1, '0, 32'd0, 1'b1, '0, 32'h100 + 32'(k + 1));
        set_disp(2'b00, 4'd7, 1'b1, '0, 32'd0, 1'b1, '0, 32'h107);
        check("bp_disp_ready", 32'(rs.disp_ready), 32'd0);
        repeat (3) step();
        check("bp_stall_occ", 32'(occupancy), 32'd4);
        check("bp_stall_wb_tag", 32'(rs.wb_tag), 32'd1);
        check("bp_stall_wb_data", rs.wb_data, 32'h0101_0000);
        rs.wb_ready = 1'b1;
        send(2'b00, 4'd7, 1'b1, '0, 32'd0, 1'b1, '0, 32'h107);
        for (int t = 0; t < 60 && got_tag.size() < 7; t++) step();
        repeat (3) step();
        check("bp_drain_count", 32'(got_tag.size()), 32'd7);
        for (int k = 0; k < 7 && k < got_tag.size(); k++) begin
            check($sformatf("bp_drain%0d_tag", k), 32'(got_tag[k]), 32'(k + 1));
            check($sformatf("bp_drain%0d_data", k), got_data[k], (32'h100 + 32'(k + 1)) << 16);
        end

        // flush with entries, EX and WB all occupied
        rs.wb_ready = 1'b0;
        for (int k = 0; k < 5; k++)
            send(2'b10, TAG_W'(k + 1), 1'b1, '0, 32'd1, 1'b1, '0, 32'd2);
        check("flush_pre_occ", 32'(occupancy), 32'd3);
        check("flush_pre_wb_valid", 32'(rs.wb_valid), 32'd1);
        check("flush_pre_fu_aluc", 32'(rs.fu_aluc), 32'd2);
        flush = 1'b1;
        set_disp(2'b10, 4'd15, 1'b1, '0, 32'd1, 1'b1, '0, 32'd2);
        step();
        flush = 1'b0;
        idle();
        check("flush_occ", 32'(occupancy), 32'd0);
        check("flush_wb_valid", 32'(rs.wb_valid), 32'd0);
        check("flush_fu_aluc", 32'(rs.fu_aluc), 32'd0);
        check("flush_disp_ready", 32'(rs.disp_ready), 32'd1);
        rs.wb_ready = 1'b1;
        repeat (3) step();
        check("flush_after_occ", 32'(occupancy), 32'd0);
        check("flush_after_wb_valid", 32'(rs.wb_valid), 32'd0);

        // asynchronous reset in the middle of backpressure
        rs.wb_ready = 1'b0;
        for (int k = 0; k < 6; k++)
            send(2'b11, TAG_W'(k + 8), 1'b1, '0, 32'd7, 1'b1, '0, 32'd9);
        check("rst_pre_occ", 32'(occupancy), 32'd4);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_rel_disp_ready", 32'(rs.disp_ready), 32'd1);
        check("midrst_rel_occ", 32'(occupancy), 32'd0);
        rs.wb_ready = 1'b1;
        repeat (4) step();
        check("midrst_no_wb", 32'(rs.wb_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
